// File: rtl/rv32_wb_arbiter.sv
// Write-back arbiter for rv32im: round-robin select onto the single regfile write port.
// Optional busy-register scoreboard for RAW/WAW stalls, built when RV32_WB_SCOREBOARD_EN is defined.
module rv32_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*5-1:0]    req_rd_i,
    input  logic [NREQ*XLEN-1:0] req_val_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 we_o,
    output logic [4:0]           rd_addr_o,
    output logic [XLEN-1:0]      rd_val_o,
    input  logic                 iss_valid_i,
    input  logic [4:0]           iss_rd_i,
    output logic                 iss_ready_o,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    output logic                 rs1_busy_o,
    output logic                 rs2_busy_o
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   last;
    logic [PW-1:0]   gidx;
    logic [PW:0]     cand;
    logic [NREQ-1:0] grant;
    logic            xfer;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_val;

    // Search last+1 .. last+NREQ (mod NREQ); first valid requester wins.
    always_comb begin
        grant = '0;
        gidx  = last;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (grant == '0 && req_valid_i[cand[PW-1:0]]) begin
                grant[cand[PW-1:0]] = 1'b1;
                gidx = cand[PW-1:0];
            end
        end
        if (rst_i) begin
            grant = '0;
        end
    end

    assign req_ready_o = grant;
    assign xfer        = |grant;
    assign sel_rd      = req_rd_i[gidx*5 +: 5];
    assign sel_val     = req_val_i[gidx*XLEN +: XLEN];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last      <= PW'(NREQ - 1);
            we_o      <= 1'b0;
            rd_addr_o <= '0;
            rd_val_o  <= '0;
        end else begin
            we_o <= xfer && (sel_rd != 5'd0);
            if (xfer) begin
                last <= gidx;
            end
            // x0 writes are consumed but never reach the regfile
            if (xfer && sel_rd != 5'd0) begin
                rd_addr_o <= sel_rd;
                rd_val_o  <= sel_val;
            end
        end
    end

`ifdef RV32_WB_SCOREBOARD_EN
    logic [31:0] busy;
    logic [31:0] busy_set;
    logic [31:0] busy_clr;

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (iss_valid_i && iss_ready_o && iss_rd_i != 5'd0) begin
            busy_set[iss_rd_i] = 1'b1;
        end
        if (we_o) begin
            busy_clr[rd_addr_o] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle reissue stays busy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~busy_clr) | busy_set) & 32'hFFFF_FFFE;
        end
    end

    assign iss_ready_o = ~busy[iss_rd_i];
    assign rs1_busy_o  = busy[rs1_i];
    assign rs2_busy_o  = busy[rs2_i];
`else
    logic unused_sb;

    assign unused_sb   = ^{iss_valid_i, iss_rd_i, rs1_i, rs2_i};
    assign iss_ready_o = 1'b1;
    assign rs1_busy_o  = 1'b0;
    assign rs2_busy_o  = 1'b0;
`endif

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Directed bench for rv32_wb_arbiter: grants checked inline, write-backs checked
// by a negedge monitor against a queue of expected {rd, val} pairs.
module tb_rv32_wb_arbiter;

`ifdef RV32_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [4:0]  rd_a [3];
    logic [31:0] val_a [3];
    logic [14:0] req_rd;
    logic [95:0] req_val;
    logic [2:0]  req_ready;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_val;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;

    int  n_tests = 0;
    int  n_fail  = 0;
    wb_t exp_q[$];

    assign req_rd  = {rd_a[2], rd_a[1], rd_a[0]};
    assign req_val = {val_a[2], val_a[1], val_a[0]};

    always #5 clk = ~clk;

    rv32_wb_arbiter #(.NREQ(3), .XLEN(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_rd_i    (req_rd),
        .req_val_i   (req_val),
        .req_ready_o (req_ready),
        .we_o        (we),
        .rd_addr_o   (rd_addr),
        .rd_val_o    (rd_val),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .iss_ready_o (iss_ready),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .rs1_busy_o  (rs1_busy),
        .rs2_busy_o  (rs2_busy)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Monitor: every regfile write must match the oldest expected write-back.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb", {27'd0, rd_addr, rd_val}, 64'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_rd", 64'(rd_addr), 64'(e.rd));
                check("wb_val", 64'(rd_val), 64'(e.val));
            end
        end
    end

    int exp_g [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        rs1       = '0;
        rs2       = '0;
        for (int k = 0; k < 3; k++) begin
            rd_a[k]  = '0;
            val_a[k] = '0;
        end
        #1;
        req_valid = 3'b111;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_we", 64'(we), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_rd_val", 64'(rd_val), 64'd0);
        check("rst_iss_ready", 64'(iss_ready), 64'd1);
        check("rst_rs1_busy", 64'(rs1_busy), 64'd0);
        req_valid = '0;
        step();
        rst = 1'b0;

        // Single request from requester 1
        step();
        req_valid = 3'b010;
        rd_a[1]   = 5'd5;
        val_a[1]  = 32'h0000_00F0;
        #1;
        check("single_ready", 64'(req_ready), 64'b010);
        exp_q.push_back('{5'd5, 32'h0000_00F0});
        step();
        req_valid = '0;
        check("single_we", 64'(we), 64'd1);
        check("single_rd", 64'(rd_addr), 64'd5);
        step();
        check("single_we_drop", 64'(we), 64'd0);

        // Round-robin with all requesters valid
        do_reset();
        for (int k = 0; k < 3; k++) begin
            rd_a[k]  = 5'(10 + k);
            val_a[k] = 32'(100 * (k + 1));
        end
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            int g;
            g = exp_g[i];
            #1;
            check($sformatf("rr_grant%0d", i), 64'(req_ready), 64'(1 << g));
            exp_q.push_back('{rd_a[g], val_a[g]});
            step();
            val_a[g] = val_a[g] + 32'd1;
        end
        req_valid = '0;

        // x0 write: accepted, no regfile write, pointer advances
        req_valid = 3'b001;
        rd_a[0]   = 5'd0;
        val_a[0]  = 32'd654;
        #1;
        check("x0_ready", 64'(req_ready), 64'b001);
        step();
        req_valid = '0;
        step();
        check("x0_no_we", 64'(we), 64'd0);
        req_valid = 3'b011;
        rd_a[0]   = 5'd13;
        val_a[0]  = 32'd1300;
        rd_a[1]   = 5'd14;
        val_a[1]  = 32'd1400;
        #1;
        check("x0_next_winner", 64'(req_ready), 64'b010);
        exp_q.push_back('{5'd14, 32'd1400});
        step();
        req_valid = '0;
        step();

        // RAW/WAW tracking on x3
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        #1;
        check("iss3_ready", 64'(iss_ready), 64'd1);
        step();
        iss_valid = 1'b0;
        rs1       = 5'd3;
        rs2       = 5'd3;
        #1;
        check("raw_rs1_busy", 64'(rs1_busy), 64'(SB));
        check("raw_rs2_busy", 64'(rs2_busy), 64'(SB));
        check("waw_iss_ready", 64'(iss_ready), 64'(!SB));
        req_valid = 3'b100;
        rd_a[2]   = 5'd3;
        val_a[2]  = 32'd546;
        #1;
        check("sb_wb_ready", 64'(req_ready), 64'b100);
        exp_q.push_back('{5'd3, 32'd546});
        step();
        req_valid = '0;
        #1;
        check("sb_busy_out_cycle", 64'(rs1_busy), 64'(SB));
        step();
        check("sb_busy_cleared", 64'(rs1_busy), 64'd0);
        check("sb_iss_ready_back", 64'(iss_ready), 64'd1);

        // Set/clear collision on x7
        req_valid = 3'b001;
        rd_a[0]   = 5'd7;
        val_a[0]  = 32'h77;
        #1;
        check("col_ready", 64'(req_ready), 64'b001);
        exp_q.push_back('{5'd7, 32'h77});
        step();
        req_valid = '0;
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        #1;
        check("col_we", 64'(we), 64'd1);
        check("col_iss_ready", 64'(iss_ready), 64'd1);
        step();
        iss_valid = 1'b0;
        rs1       = 5'd7;
        #1;
        check("col_set_wins", 64'(rs1_busy), 64'(SB));
        check("col_waw", 64'(iss_ready), 64'(!SB));

        // Asynchronous reset with a write and busy bit in flight
        req_valid = 3'b010;
        rd_a[1]   = 5'd4;
        val_a[1]  = 32'h44;
        iss_valid = 1'b1;
        iss_rd    = 5'd4;
        #1;
        check("ar_ready", 64'(req_ready), 64'b010);
        step();
        req_valid = '0;
        iss_valid = 1'b0;
        iss_rd    = 5'd7;
        rs1       = 5'd4;
        rs2       = 5'd7;
        #1;
        check("ar_we_before", 64'(we), 64'd1);
        check("ar_rd_before", 64'(rd_addr), 64'd4);
        check("ar_busy_before", 64'(rs1_busy), 64'(SB));
        rst = 1'b1;
        #1;
        check("ar_we", 64'(we), 64'd0);
        check("ar_rd_addr", 64'(rd_addr), 64'd0);
        check("ar_rd_val", 64'(rd_val), 64'd0);
        check("ar_rs1_busy", 64'(rs1_busy), 64'd0);
        check("ar_rs2_busy", 64'(rs2_busy), 64'd0);
        check("ar_iss_ready", 64'(iss_ready), 64'd1);
        req_valid = 3'b111;
        #1;
        check("ar_ready_zero", 64'(req_ready), 64'd0);
        step();
        check("ar_no_write", 64'(we), 64'd0);
        rst       = 1'b0;
        req_valid = '0;
        step();
        step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
